seg_scan: RTL

- Downstream consumer of the free-running 32-bit clock-divider count.
- Time-multiplexes an 8-digit common-anode 7-segment display from a 32-bit hex word, one digit per scan tick.
- Double-buffers the display data so a new word only takes effect at a frame boundary.
- Inserts a short all-off guard interval between digits to suppress ghosting.

---
 rtl/seg_scan.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: 8-digit common-anode 7-segment scanner with double-buffered data.
// Optional leading-zero suppression via `define SEG_SCAN_LZS_EN.
module seg_scan #(
  parameter int SCAN_BIT     = 17,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic        load,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0] GC_INIT =
    CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef enum logic {DRIVE, GUARD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic [31:0]   sh_dat_q, sh_dat_d;
  logic [7:0]    sh_dp_q, sh_dp_d;
  logic [7:0]    sh_bl_q, sh_bl_d;
  logic [31:0]   ac_dat_q, ac_dat_d;
  logic [7:0]    ac_dp_q, ac_dp_d;
  logic [7:0]    ac_bl_q, ac_bl_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic          tick;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          unused_clkdiv;

  assign unused_clkdiv = ^clkdiv;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0010000;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;
      4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

`ifdef SEG_SCAN_LZS_EN
  logic [2:0] top;
`endif

  always_comb begin
    tick     = clkdiv[SCAN_BIT] & ~prev_q;
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ac_dat_d = ac_dat_q;
    ac_dp_d  = ac_dp_q;
    ac_bl_d  = ac_bl_q;
    frame_d  = 1'b0;

    unique case (state_q)
      DRIVE: begin
        if (tick) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            frame_d  = 1'b1;
            ac_dat_d = sh_dat_q;
            ac_dp_d  = sh_dp_q;
            ac_bl_d  = sh_bl_q;
          end
          if (GUARD_CYCLES > 0) begin
            state_d = GUARD;
            cnt_d   = GC_INIT;
          end
        end
      end
      GUARD: begin
        // ticks landing here are intentionally dropped
        if (cnt_q == '0) state_d = DRIVE;
        else             cnt_d   = cnt_q - CW'(1);
      end
    endcase

    sh_dat_d = load ? data  : sh_dat_q;
    sh_dp_d  = load ? dp    : sh_dp_q;
    sh_bl_d  = load ? blank : sh_bl_q;

    nib   = ac_dat_d[{idx_d, 2'b00} +: 4];
    glyph = hex7(nib);
`ifdef SEG_SCAN_LZS_EN
    top = 3'd0;
    for (int i = 1; i < 8; i++)
      if (ac_dat_d[4*i +: 4] != 4'h0) top = 3'(i);
    if (idx_d > top) glyph = 7'h7F;
`endif

    an_d  = ac_bl_d[idx_d] ? 8'hFF : ~(8'b1 << idx_d);
    seg_d = {~ac_dp_d[idx_d], glyph};
    if (state_d == GUARD) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DRIVE;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      sh_dat_q <= '0;
      sh_dp_q  <= '0;
      sh_bl_q  <= '0;
      ac_dat_q <= '0;
      ac_dp_q  <= '0;
      ac_bl_q  <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      prev_q   <= clkdiv[SCAN_BIT];
      sh_dat_q <= sh_dat_d;
      sh_dp_q  <= sh_dp_d;
      sh_bl_q  <= sh_bl_d;
      ac_dat_q <= ac_dat_d;
      ac_dp_q  <= ac_dp_d;
      ac_bl_q  <= ac_bl_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule
